// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg_pkg;

    // Segment patterns {g,f,e,d,c,b,a} for BCD codes; 10..15 render blank.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        BLANKING = 2'd1,
        SHOW     = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of the producer-side write port and the display pin outputs.
// Latency: n/a (wiring only).
// Backpressure: none; writes are always accepted by the slave.
// master: drives en/wr_*/lz_sup, observes dig_sel/dout/frame_tick. slave: the reverse.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    localparam int AW = $clog2(DIGITS);

    logic              en;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [3:0]        wr_data;
    logic              wr_dp;
    logic              lz_sup;
    logic [DIGITS-1:0] dig_sel;
    logic [7:0]        dout;
    logic              frame_tick;

    modport master (
        output en, wr_en, wr_addr, wr_data, wr_dp, lz_sup,
        input  dig_sel, dout, frame_tick
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, wr_dp, lz_sup,
        output dig_sel, dout, frame_tick
    );
endinterface

// File: rtl/seg_decode.sv
// BCD to 7-segment lookup {g,f,e,d,c,b,a}; codes above 9 give a blank digit.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (4-bit code in), seg (7-bit active-high segments out).
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[bcd];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of DIGITS 7-segment digits with dwell time and blank gap.
// Latency: outputs registered; a digit write shows on dout one cycle after the write edge.
// Backpressure: none; register-file writes are accepted in every state.
// Ports: clk, rst (async, active-high), bus (slave modport: en, wr_*, lz_sup in; dig_sel, dout, frame_tick out).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DWELL  = 50000,
    parameter int BLANK  = 500
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int AW   = $clog2(DIGITS);
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    scan_state_t       state, nxt_state;
    logic [AW-1:0]     idx, nxt_idx;
    logic [CW-1:0]     cnt, nxt_cnt;

    logic [3:0]        val [DIGITS];
    logic [DIGITS-1:0] dp;
    logic [DIGITS-1:0] upper_zero;
    logic              suppress;
    logic [3:0]        cur_bcd;
    logic [6:0]        cur_seg;

    // Digit register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                val[i] <= 4'd0;
            end
            dp <= '0;
        end else if (bus.wr_en && (int'(bus.wr_addr) < DIGITS)) begin
            val[bus.wr_addr] <= bus.wr_data;
            dp[bus.wr_addr]  <= bus.wr_dp;
        end
    end

    // upper_zero[i]: digit i and every higher digit hold zero.
    always_comb begin
        logic run;
        upper_zero = '0;
        run        = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run           = run & (val[i] == 4'd0);
            upper_zero[i] = run;
        end
    end

    // Outputs are registered from the next state, so the decoder looks at
    // the digit about to be driven rather than the one currently shown.
    assign cur_bcd  = val[nxt_idx];
    assign suppress = bus.lz_sup && (nxt_idx != '0) && upper_zero[nxt_idx];

    seg_decode u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OFF;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        if (!bus.en) begin
            nxt_state = OFF;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                OFF: begin
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                    nxt_state = (BLANK == 0) ? SHOW : BLANKING;
                end
                BLANKING: begin
                    if (cnt == CW'(BLANK - 1)) begin
                        nxt_state = SHOW;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt == CW'(DWELL - 1)) begin
                        nxt_cnt   = '0;
                        nxt_idx   = (idx == AW'(DIGITS - 1)) ? '0 : idx + AW'(1);
                        nxt_state = (BLANK == 0) ? SHOW : BLANKING;
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end
                default: begin
                    nxt_state = OFF;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // frame_tick marks entry into an idx-0 visit; staying in SHOW at idx 0 is not an entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dig_sel    <= '1;
            bus.dout       <= SEG_BLANK;
            bus.frame_tick <= 1'b0;
        end else if (nxt_state == SHOW) begin
            bus.dig_sel    <= ~(DIGITS'(1) << nxt_idx);
            bus.dout       <= suppress ? SEG_BLANK : {dp[nxt_idx], cur_seg};
            bus.frame_tick <= (nxt_idx == '0) && !((state == SHOW) && (idx == '0));
        end else begin
            bus.dig_sel    <= '1;
            bus.dout       <= SEG_BLANK;
            bus.frame_tick <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: three instances (gap, no gap, three digits).
// Outputs are run-length encoded per instance and compared against queued expectations.
module tb_seg_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(4)) if_a ();
    seg_scan_ctrl_if #(.DIGITS(4)) if_b ();
    seg_scan_ctrl_if #(.DIGITS(3)) if_c ();

    seg_scan_ctrl #(.DIGITS(4), .DWELL(4), .BLANK(1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    seg_scan_ctrl #(.DIGITS(4), .DWELL(4), .BLANK(0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    seg_scan_ctrl #(.DIGITS(3), .DWELL(2), .BLANK(0)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct packed {
        logic [7:0]  sel;
        logic [7:0]  seg;
        logic        ft;
        logic [15:0] len;   // 0 = length not checked
    } run_t;

    run_t qa[$];
    run_t qb[$];
    run_t qc[$];
    int   tests = 0;
    int   fails = 0;

    logic [16:0] obs  [3];
    logic [16:0] prev [3];
    int          runlen [3];
    bit          started [3];

    always_comb begin
        obs[0] = {4'h0, if_a.dig_sel, if_a.dout, if_a.frame_tick};
        obs[1] = {4'h0, if_b.dig_sel, if_b.dout, if_b.frame_tick};
        obs[2] = {5'h0, if_c.dig_sel, if_c.dout, if_c.frame_tick};
    end

    task automatic push(input int k, input logic [7:0] sel, input logic [7:0] seg,
                        input logic ft, input int len);
        run_t r;
        r = '{sel: sel, seg: seg, ft: ft, len: 16'(len)};
        case (k)
            0:       qa.push_back(r);
            1:       qb.push_back(r);
            default: qc.push_back(r);
        endcase
    endtask

    task automatic check_run(input int k, input logic [16:0] got, input int len);
        run_t e;
        bit   empty;
        empty = 1'b0;
        e     = '0;
        case (k)
            0:       if (qa.size() == 0) empty = 1'b1; else e = qa.pop_front();
            1:       if (qb.size() == 0) empty = 1'b1; else e = qb.pop_front();
            default: if (qc.size() == 0) empty = 1'b1; else e = qc.pop_front();
        endcase
        tests++;
        if (empty) begin
            fails++;
            $display("FAIL dut%0d unexpected run: sel=%h seg=%h ft=%b len=%0d, expected none",
                     k, got[16:9], got[8:1], got[0], len);
        end else if (got[16:9] != e.sel || got[8:1] != e.seg || got[0] != e.ft ||
                     (e.len != 0 && int'(e.len) != len)) begin
            fails++;
            $display("FAIL dut%0d run: got sel=%h seg=%h ft=%b len=%0d, want sel=%h seg=%h ft=%b len=%0d",
                     k, got[16:9], got[8:1], got[0], len, e.sel, e.seg, e.ft, e.len);
        end
    endtask

    // Monitor: a run is reported when the output tuple changes.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!started[k]) begin
                started[k] = 1'b1;
                prev[k]    = obs[k];
                runlen[k]  = 1;
            end else if (obs[k] != prev[k]) begin
                check_run(k, prev[k], runlen[k]);
                prev[k]   = obs[k];
                runlen[k] = 1;
            end else begin
                runlen[k]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_en(input int k, input logic v);
        case (k)
            0:       if_a.en = v;
            1:       if_b.en = v;
            default: if_c.en = v;
        endcase
    endtask

    task automatic wr(input int k, input logic [1:0] addr, input logic [3:0] data, input logic dpv);
        case (k)
            0: begin if_a.wr_en = 1'b1; if_a.wr_addr = addr; if_a.wr_data = data; if_a.wr_dp = dpv; end
            1: begin if_b.wr_en = 1'b1; if_b.wr_addr = addr; if_b.wr_data = data; if_b.wr_dp = dpv; end
            default: begin if_c.wr_en = 1'b1; if_c.wr_addr = addr; if_c.wr_data = data; if_c.wr_dp = dpv; end
        endcase
        tick(1);
        if_a.wr_en = 1'b0;
        if_b.wr_en = 1'b0;
        if_c.wr_en = 1'b0;
    endtask

    // One frame of a 4-digit instance: DWELL=4, gap of 'gap' dark cycles after each digit.
    task automatic push_frame4(input int k, input int gap, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3, input bit tail);
        push(k, 8'h0E, s0, 1'b1, 1);
        push(k, 8'h0E, s0, 1'b0, 3);
        if (gap != 0) push(k, 8'h0F, 8'h00, 1'b0, gap);
        push(k, 8'h0D, s1, 1'b0, 4);
        if (gap != 0) push(k, 8'h0F, 8'h00, 1'b0, gap);
        push(k, 8'h0B, s2, 1'b0, 4);
        if (gap != 0) push(k, 8'h0F, 8'h00, 1'b0, gap);
        push(k, 8'h07, s3, 1'b0, 4);
        if (gap != 0 && tail) push(k, 8'h0F, 8'h00, 1'b0, gap);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.en = 0; if_a.wr_en = 0; if_a.wr_addr = '0; if_a.wr_data = '0; if_a.wr_dp = 0; if_a.lz_sup = 0;
        if_b.en = 0; if_b.wr_en = 0; if_b.wr_addr = '0; if_b.wr_data = '0; if_b.wr_dp = 0; if_b.lz_sup = 0;
        if_c.en = 0; if_c.wr_en = 0; if_c.wr_addr = '0; if_c.wr_data = '0; if_c.wr_dp = 0; if_c.lz_sup = 0;
        tick(3);
        rst = 1'b0;

        // ---- A: basic scan with gap, then reset mid-SHOW ----
        push(0, 8'h0F, 8'h00, 1'b0, 0);
        push_frame4(0, 1, 8'h06, 8'h5B, 8'h4F, 8'h66, 1'b1);
        push(0, 8'h0E, 8'h06, 1'b1, 1);
        push(0, 8'h0E, 8'h06, 1'b0, 1);       // cut short by reset
        for (int i = 0; i < 4; i++) wr(0, 2'(i), 4'(i + 1), 1'b0);
        set_en(0, 1'b1);
        tick(24);
        rst = 1'b1;
        set_en(0, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(20);

        // Register file cleared by reset: every digit shows 0.
        push(0, 8'h0F, 8'h00, 1'b0, 0);
        push_frame4(0, 1, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b0);
        set_en(0, 1'b1);
        tick(20);
        set_en(0, 1'b0);
        tick(3);

        // Live write of idx1 during its SHOW, then en drop mid-SHOW of idx2.
        push(0, 8'h0F, 8'h00, 1'b0, 0);
        push(0, 8'h0E, 8'h06, 1'b1, 1);
        push(0, 8'h0E, 8'h06, 1'b0, 3);
        push(0, 8'h0F, 8'h00, 1'b0, 1);
        push(0, 8'h0D, 8'h5B, 1'b0, 3);
        push(0, 8'h0D, 8'h7F, 1'b0, 1);
        push(0, 8'h0F, 8'h00, 1'b0, 1);
        push(0, 8'h0B, 8'h4F, 1'b0, 4);
        push(0, 8'h0F, 8'h00, 1'b0, 1);
        push(0, 8'h07, 8'h66, 1'b0, 4);
        push(0, 8'h0F, 8'h00, 1'b0, 1);
        push_frame4(0, 1, 8'h06, 8'h7F, 8'h4F, 8'h66, 1'b1);
        push(0, 8'h0E, 8'h06, 1'b1, 1);
        push(0, 8'h0E, 8'h06, 1'b0, 3);
        push(0, 8'h0F, 8'h00, 1'b0, 1);
        push(0, 8'h0D, 8'h7F, 1'b0, 4);
        push(0, 8'h0F, 8'h00, 1'b0, 1);
        push(0, 8'h0B, 8'h4F, 1'b0, 2);       // cut short by en=0
        for (int i = 0; i < 4; i++) wr(0, 2'(i), 4'(i + 1), 1'b0);
        set_en(0, 1'b1);
        tick(8);
        wr(0, 2'd1, 4'd8, 1'b0);
        tick(44);
        set_en(0, 1'b0);
        tick(5);
        push(0, 8'h0F, 8'h00, 1'b0, 0);
        push(0, 8'h0E, 8'h06, 1'b1, 1);
        push(0, 8'h0E, 8'h06, 1'b0, 3);
        push(0, 8'h0F, 8'h00, 1'b0, 1);
        push(0, 8'h0D, 8'h7F, 1'b0, 4);
        set_en(0, 1'b1);
        tick(10);
        set_en(0, 1'b0);
        tick(5);

        // ---- B: no gap, dp, invalid code, leading-zero suppression ----
        push(1, 8'h0F, 8'h00, 1'b0, 0);
        push_frame4(1, 0, 8'h06, 8'h00, 8'hEF, 8'h07, 1'b0);
        push(1, 8'h0E, 8'h06, 1'b1, 1);
        push(1, 8'h0E, 8'h06, 1'b0, 3);
        wr(1, 2'd0, 4'd1, 1'b0);
        wr(1, 2'd1, 4'hC, 1'b0);
        wr(1, 2'd2, 4'd9, 1'b1);
        wr(1, 2'd3, 4'd7, 1'b0);
        set_en(1, 1'b1);
        tick(20);
        set_en(1, 1'b0);
        tick(3);

        push(1, 8'h0F, 8'h00, 1'b0, 0);
        push_frame4(1, 0, 8'h3F, 8'h6D, 8'h00, 8'h00, 1'b0);
        push(1, 8'h0F, 8'h00, 1'b0, 0);
        push_frame4(1, 0, 8'h3F, 8'h6D, 8'h3F, 8'hBF, 1'b0);
        wr(1, 2'd0, 4'd0, 1'b0);
        wr(1, 2'd1, 4'd5, 1'b0);
        wr(1, 2'd2, 4'd0, 1'b0);
        wr(1, 2'd3, 4'd0, 1'b1);
        if_b.lz_sup = 1'b1;
        set_en(1, 1'b1);
        tick(16);
        set_en(1, 1'b0);
        tick(2);
        if_b.lz_sup = 1'b0;
        set_en(1, 1'b1);
        tick(16);
        set_en(1, 1'b0);
        tick(3);

        // ---- C: three digits, wrap 2->0, out-of-range write ignored ----
        push(2, 8'h07, 8'h00, 1'b0, 0);
        push(2, 8'h06, 8'h06, 1'b1, 1);
        push(2, 8'h06, 8'h06, 1'b0, 1);
        push(2, 8'h05, 8'h5B, 1'b0, 2);
        push(2, 8'h03, 8'h4F, 1'b0, 2);
        push(2, 8'h06, 8'h06, 1'b1, 1);
        push(2, 8'h06, 8'h06, 1'b0, 1);
        wr(2, 2'd0, 4'd1, 1'b0);
        wr(2, 2'd1, 4'd2, 1'b0);
        wr(2, 2'd2, 4'd3, 1'b0);
        wr(2, 2'd3, 4'd8, 1'b1);
        set_en(2, 1'b1);
        tick(8);
        set_en(2, 1'b0);
        tick(5);

        // Every queued run must have been observed.
        tests++;
        if (qa.size() != 0) begin fails++; $display("FAIL dut0 drain: %0d runs left, want 0", qa.size()); end
        tests++;
        if (qb.size() != 0) begin fails++; $display("FAIL dut1 drain: %0d runs left, want 0", qb.size()); end
        tests++;
        if (qc.size() != 0) begin fails++; $display("FAIL dut2 drain: %0d runs left, want 0", qc.size()); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
